// File: rtl/user_clksel_pkg.sv
// Shared types, default parameters and counter sizing for the clock-select controller.
package user_clksel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_SETTLE_CYCLES   = 8;
    localparam int unsigned DEF_DWELL_CYCLES    = 1024;
    localparam int unsigned DEF_CNT_W           = 16;

    // Bits needed to hold a down/up count of 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/user_sync_debounce.sv
// Multi-flop synchroniser followed by a stable-count debouncer.
// With DEBOUNCE_CYCLES = 1 the debouncer is bypassed and the block is a pure synchroniser.
module user_sync_debounce
    import user_clksel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 1) begin : g_bypass
            assign q = synced;
        end else begin : g_debounce
            localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);

            logic [DW-1:0] cnt_q;
            logic          deb_q;

            // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (synced == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt_q <= '0;
                    deb_q <= synced;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end

            assign q = deb_q;
        end
    endgenerate

endmodule

// File: rtl/user_clksel_ctrl.sv
// Clock-source select controller feeding the select input of user_bufgmux.
// Optional automatic failover is compiled in with `define USER_CLKSEL_FAILOVER_EN.
module user_clksel_ctrl
    import user_clksel_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int unsigned DWELL_CYCLES    = DEF_DWELL_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             sel_req,
    input  logic             clk1_ok,
    input  logic             clk2_ok,
    input  logic             auto_fail_en,
    output logic             selection,
    output logic             switch_busy,
    output logic             switch_done,
    output logic             req_blocked,
    output logic             fault,
    output logic [CNT_W-1:0] switch_count
);

    localparam int unsigned TMAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW   = cnt_width(TMAX);

    logic          req_deb;
    logic          ok1;
    logic          ok2;
    state_t        state;
    logic [TW-1:0] timer_q;

    logic cur_ok_c;
    logic req_ok_c;
    logic both_bad_c;
    logic fail_c;
    logic manual_c;
    logic blocked_c;

    user_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_req_sync (
        .clk (aclk),
        .rst (areset),
        .d   (sel_req),
        .q   (req_deb)
    );

    user_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_ok1_sync (
        .clk (aclk),
        .rst (areset),
        .d   (clk1_ok),
        .q   (ok1)
    );

    user_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (1)
    ) u_ok2_sync (
        .clk (aclk),
        .rst (areset),
        .d   (clk2_ok),
        .q   (ok2)
    );

    // Decide whether a failover or manual switch is wanted this cycle; the target is always the other clock.
    always_comb begin
        cur_ok_c   = selection ? ok2 : ok1;
        req_ok_c   = req_deb ? ok2 : ok1;
        both_bad_c = !ok1 && !ok2;
`ifdef USER_CLKSEL_FAILOVER_EN
        fail_c     = auto_fail_en && !cur_ok_c && !both_bad_c;
`else
        fail_c     = 1'b0;
`endif
        manual_c   = !fail_c && !both_bad_c && (req_deb != selection) && req_ok_c;
        blocked_c  = !fail_c && (req_deb != selection) && !req_ok_c;
    end

`ifndef USER_CLKSEL_FAILOVER_EN
    logic unused_fail_inputs;
    assign unused_fail_inputs = auto_fail_en ^ cur_ok_c;
`endif

    // Main select FSM with registered status outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            timer_q      <= '0;
            selection    <= 1'b0;
            switch_busy  <= 1'b0;
            switch_done  <= 1'b0;
            req_blocked  <= 1'b0;
            fault        <= 1'b0;
            switch_count <= '0;
        end else begin
            switch_done <= 1'b0;
            req_blocked <= blocked_c;
            fault       <= both_bad_c;
            case (state)
                IDLE: begin
                    if (fail_c || manual_c) begin
                        selection   <= ~selection;
                        switch_busy <= 1'b1;
                        timer_q     <= TW'(SETTLE_CYCLES - 1);
                        state       <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (timer_q == '0) begin
                        switch_busy <= 1'b0;
                        switch_done <= 1'b1;
                        if (switch_count != '1) begin
                            switch_count <= switch_count + CNT_W'(1);
                        end
                        timer_q     <= TW'(DWELL_CYCLES - 1);
                        state       <= HOLD;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                HOLD: begin
                    // Manual requests wait for dwell expiry; a failover cuts the dwell short.
                    if (fail_c) begin
                        selection   <= ~selection;
                        switch_busy <= 1'b1;
                        timer_q     <= TW'(SETTLE_CYCLES - 1);
                        state       <= SWITCH;
                    end else if (timer_q == '0) begin
                        state <= IDLE;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_user_clksel_ctrl.sv
// Directed self-checking bench for user_clksel_ctrl (DWELL_CYCLES = 64, other parameters default).
module tb_user_clksel_ctrl;

    logic        aclk;
    logic        areset;
    logic        sel_req;
    logic        clk1_ok;
    logic        clk2_ok;
    logic        auto_fail_en;
    logic        selection;
    logic        switch_busy;
    logic        switch_done;
    logic        req_blocked;
    logic        fault;
    logic [15:0] switch_count;

    int n_pass = 0;
    int n_chk  = 0;

    user_clksel_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .SETTLE_CYCLES   (8),
        .DWELL_CYCLES    (64),
        .CNT_W           (16)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .sel_req      (sel_req),
        .clk1_ok      (clk1_ok),
        .clk2_ok      (clk2_ok),
        .auto_fail_en (auto_fail_en),
        .selection    (selection),
        .switch_busy  (switch_busy),
        .switch_done  (switch_done),
        .req_blocked  (req_blocked),
        .fault        (fault),
        .switch_count (switch_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sel"},   32'(selection),    32'd0);
        chk({tag, "_busy"},  32'(switch_busy),  32'd0);
        chk({tag, "_done"},  32'(switch_done),  32'd0);
        chk({tag, "_blk"},   32'(req_blocked),  32'd0);
        chk({tag, "_fault"}, 32'(fault),        32'd0);
        chk({tag, "_cnt"},   32'(switch_count), 32'd0);
    endtask

    initial begin
        areset       = 1'b1;
        sel_req      = 1'b0;
        clk1_ok      = 1'b1;
        clk2_ok      = 1'b1;
        auto_fail_en = 1'b0;

        // Power-on reset
        tick(3);
        chk_all_zero("por");
        areset = 1'b0;
        tick(5);
        chk("por_settled_fault", 32'(fault), 32'd0);
        chk("por_settled_sel", 32'(selection), 32'd0);

        // Manual switch 0 -> 1: selection changes on the 19th edge
        sel_req = 1'b1;
        tick(18);
        chk("man_sel_before", 32'(selection), 32'd0);
        tick(1);
        chk("man_sel_after", 32'(selection), 32'd1);
        chk("man_busy_first", 32'(switch_busy), 32'd1);
        tick(7);
        chk("man_busy_last", 32'(switch_busy), 32'd1);
        chk("man_done_early", 32'(switch_done), 32'd0);
        tick(1);
        chk("man_busy_end", 32'(switch_busy), 32'd0);
        chk("man_done", 32'(switch_done), 32'd1);
        chk("man_count", 32'(switch_count), 32'd1);

        // Dwell: request back to 0 straight away, held off for the 64-cycle HOLD
        sel_req = 1'b0;
        tick(1);
        chk("dwell_done_pulse", 32'(switch_done), 32'd0);
        tick(30);
        chk("dwell_mid_sel", 32'(selection), 32'd1);
        tick(33);
        chk("dwell_last_sel", 32'(selection), 32'd1);
        tick(1);
        chk("dwell_switch_sel", 32'(selection), 32'd0);
        chk("dwell_switch_busy", 32'(switch_busy), 32'd1);
        tick(8);
        chk("dwell_done", 32'(switch_done), 32'd1);
        chk("dwell_count", 32'(switch_count), 32'd2);

        // Glitches of 10 and 15 cycles are rejected
        tick(70);
        sel_req = 1'b1;
        tick(10);
        sel_req = 1'b0;
        tick(30);
        chk("glitch10_sel", 32'(selection), 32'd0);
        chk("glitch10_cnt", 32'(switch_count), 32'd2);
        sel_req = 1'b1;
        tick(15);
        sel_req = 1'b0;
        tick(30);
        chk("glitch15_sel", 32'(selection), 32'd0);
        chk("glitch15_busy", 32'(switch_busy), 32'd0);

        // Blocked request while clk2 unhealthy, released when it recovers
        clk2_ok = 1'b0;
        tick(5);
        chk("blk_fault", 32'(fault), 32'd0);
        sel_req = 1'b1;
        tick(20);
        chk("blk_flag", 32'(req_blocked), 32'd1);
        chk("blk_sel", 32'(selection), 32'd0);
        clk2_ok = 1'b1;
        tick(2);
        chk("blk_flag_hold", 32'(req_blocked), 32'd1);
        chk("blk_sel_hold", 32'(selection), 32'd0);
        tick(1);
        chk("blk_release_flag", 32'(req_blocked), 32'd0);
        chk("blk_release_sel", 32'(selection), 32'd1);
        tick(8);
        chk("blk_done", 32'(switch_done), 32'd1);
        chk("blk_count", 32'(switch_count), 32'd3);

        // Current clock (clk2) fails during HOLD with auto failover enabled
        auto_fail_en = 1'b1;
        clk2_ok = 1'b0;
        tick(2);
        chk("fo_sel_before", 32'(selection), 32'd1);
`ifdef USER_CLKSEL_FAILOVER_EN
        tick(1);
        chk("fo_sel_after", 32'(selection), 32'd0);
        chk("fo_busy", 32'(switch_busy), 32'd1);
`else
        tick(10);
        chk("nofo_sel", 32'(selection), 32'd1);
        chk("nofo_busy", 32'(switch_busy), 32'd0);
`endif

        // Both clocks unhealthy: fault and no further switching
        clk1_ok = 1'b0;
        tick(3);
        chk("fault_set", 32'(fault), 32'd1);
        tick(100);
        chk("fault_hold", 32'(fault), 32'd1);
`ifdef USER_CLKSEL_FAILOVER_EN
        chk("fault_sel", 32'(selection), 32'd0);
`else
        chk("fault_sel", 32'(selection), 32'd1);
`endif

        // Recover, then reset in the middle of a SWITCH
        clk1_ok      = 1'b1;
        clk2_ok      = 1'b1;
        auto_fail_en = 1'b0;
        tick(150);
        chk("recover_sel", 32'(selection), 32'd1);
        chk("recover_fault", 32'(fault), 32'd0);
        sel_req = 1'b0;
        tick(19);
        chk("midsw_sel", 32'(selection), 32'd0);
        chk("midsw_busy", 32'(switch_busy), 32'd1);
        tick(3);
        areset = 1'b1;
        tick(5);
        chk_all_zero("rst_mid");
        areset = 1'b0;
        tick(40);
        chk("post_rst_sel", 32'(selection), 32'd0);
        chk("post_rst_busy", 32'(switch_busy), 32'd0);
        chk("post_rst_cnt", 32'(switch_count), 32'd0);
        chk("post_rst_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
